bus_read_ctrl: RTL and testbench

Master-side bus transaction controller sitting directly upstream of the 7-way 32-bit read-data mux. It accepts single read/write requests from one master and decodes the address page to one of seven slaves. It drives one-hot slave selects plus the 4-bit mux select, then captures the mux output and returns it to the master with an acknowledge. Unmapped addresses are terminated with an error and zero data.

---
 rtl/bus_pkg.sv | 18 +
 rtl/bus_addr_decode.sv | 21 ++
 rtl/bus_read_ctrl.sv | 103 ++++++++++
 tb/tb_bus_read_ctrl.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared bus parameters, FSM state encoding and decode constants for the
// single-master bus controller and its address decoder.
package bus_pkg;

  localparam int unsigned AW   = 16;
  localparam int unsigned DW   = 32;
  localparam int unsigned NSLV = 7;

  localparam logic [3:0] RD_SEL_NONE = 4'b0111;
  localparam logic [7:0] PAGE_MAX    = 8'h06;

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

endpackage

// File: rtl/bus_addr_decode.sv
// Combinational page decoder: maps an 8-bit address page to a slave hit flag,
// binary slave index (RD_SEL_NONE on miss) and one-hot chip select.
module bus_addr_decode
  import bus_pkg::*;
(
  input  logic [7:0]      page,
  output logic            hit,
  output logic [3:0]      idx,
  output logic [NSLV-1:0] onehot
);

  always_comb begin
    hit = (page <= PAGE_MAX);
    idx = hit ? page[3:0] : RD_SEL_NONE;
    onehot = '0;
    for (int unsigned i = 0; i < NSLV; i++) begin
      onehot[i] = hit && (page == 8'(i));
    end
  end

endmodule

// File: rtl/bus_read_ctrl.sv
// Single-master bus transaction controller: accepts one request, drives the
// slave selects and read-mux select for one cycle, then returns ack/data.
module bus_read_ctrl
  import bus_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            m_req,
  input  logic            m_wr,
  input  logic [AW-1:0]   m_addr,
  input  logic [DW-1:0]   m_wdata,
  output logic            m_ready,
  output logic            m_ack,
  output logic            m_err,
  output logic [DW-1:0]   m_rdata,
  output logic [NSLV-1:0] s_sel,
  output logic            s_wr,
  output logic [7:0]      s_addr,
  output logic [DW-1:0]   s_wdata,
  output logic [3:0]      rd_sel,
  input  logic [DW-1:0]   rd_data_in
);

  state_t state;
  state_t state_next;

  logic            dec_hit;
  logic [3:0]      dec_idx;
  logic [NSLV-1:0] dec_onehot;

  logic wr_q;
  logic hit_q;

  bus_addr_decode u_decode (
    .page   (m_addr[15:8]),
    .hit    (dec_hit),
    .idx    (dec_idx),
    .onehot (dec_onehot)
  );

  assign m_ready = (state == IDLE) && !rst;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (m_req) state_next = ACCESS;
      ACCESS:  state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Slave-side outputs are loaded on the accepting edge so they are valid for
  // the whole ACCESS cycle; rd_sel is held through RESP for a stable mux.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_q    <= 1'b0;
      hit_q   <= 1'b0;
      m_ack   <= 1'b0;
      m_err   <= 1'b0;
      m_rdata <= '0;
      s_sel   <= '0;
      s_wr    <= 1'b0;
      s_addr  <= '0;
      s_wdata <= '0;
      rd_sel  <= RD_SEL_NONE;
    end else begin
      m_ack <= 1'b0;
      m_err <= 1'b0;
      s_sel <= '0;
      s_wr  <= 1'b0;
      unique case (state)
        IDLE: begin
          if (m_req) begin
            wr_q    <= m_wr;
            hit_q   <= dec_hit;
            s_addr  <= m_addr[7:0];
            s_wdata <= m_wdata;
            s_sel   <= dec_onehot;
            s_wr    <= m_wr && dec_hit;
            rd_sel  <= dec_idx;
          end
        end
        ACCESS: begin
        end
        RESP: begin
          m_ack  <= 1'b1;
          m_err  <= !hit_q;
          rd_sel <= RD_SEL_NONE;
          if (!wr_q) m_rdata <= hit_q ? rd_data_in : '0;
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: tb/tb_bus_read_ctrl.sv
// Directed, table-driven bench for bus_read_ctrl with a combinational
// read-mux/slave model behind rd_sel.
module tb_bus_read_ctrl;
  import bus_pkg::*;

  logic            clk = 1'b0;
  logic            rst;
  logic            m_req;
  logic            m_wr;
  logic [AW-1:0]   m_addr;
  logic [DW-1:0]   m_wdata;
  logic            m_ready;
  logic            m_ack;
  logic            m_err;
  logic [DW-1:0]   m_rdata;
  logic [NSLV-1:0] s_sel;
  logic            s_wr;
  logic [7:0]      s_addr;
  logic [DW-1:0]   s_wdata;
  logic [3:0]      rd_sel;
  logic [DW-1:0]   rd_data_in;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bus_read_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .m_req      (m_req),
    .m_wr       (m_wr),
    .m_addr     (m_addr),
    .m_wdata    (m_wdata),
    .m_ready    (m_ready),
    .m_ack      (m_ack),
    .m_err      (m_err),
    .m_rdata    (m_rdata),
    .s_sel      (s_sel),
    .s_wr       (s_wr),
    .s_addr     (s_addr),
    .s_wdata    (s_wdata),
    .rd_sel     (rd_sel),
    .rd_data_in (rd_data_in)
  );

  // Read mux plus slaves: slave 3 returns DEADBEEF, others 1000_000i.
  function automatic logic [31:0] slave_val(input logic [3:0] s);
    if (s == 4'd3)     return 32'hDEADBEEF;
    else if (s < 4'd7) return 32'h1000_0000 + 32'(s);
    else               return 32'h0;
  endfunction

  assign rd_data_in = slave_val(rd_sel);

  typedef struct {
    logic        wr;
    logic [15:0] addr;
    logic [31:0] wdata;
    logic [6:0]  exp_sel;
    logic        exp_swr;
    logic [3:0]  exp_rdsel;
    logic        exp_err;
    logic [31:0] exp_rdata;
  } vec_t;

  vec_t vecs[9];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Called at a negedge with the DUT idle; returns at the negedge of the ack cycle.
  task automatic run_txn(input int n, input vec_t v);
    chk($sformatf("v%0d ready", n), 32'(m_ready), 32'd1);
    m_req = 1'b1; m_wr = v.wr; m_addr = v.addr; m_wdata = v.wdata;
    @(negedge clk);
    m_req = 1'b0;
    chk($sformatf("v%0d acc s_sel", n), 32'(s_sel), 32'(v.exp_sel));
    chk($sformatf("v%0d acc s_wr", n), 32'(s_wr), 32'(v.exp_swr));
    chk($sformatf("v%0d acc s_addr", n), 32'(s_addr), 32'(v.addr[7:0]));
    chk($sformatf("v%0d acc s_wdata", n), s_wdata, v.wdata);
    chk($sformatf("v%0d acc rd_sel", n), 32'(rd_sel), 32'(v.exp_rdsel));
    chk($sformatf("v%0d acc ready", n), 32'(m_ready), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d resp s_sel", n), 32'(s_sel), 32'd0);
    chk($sformatf("v%0d resp s_wr", n), 32'(s_wr), 32'd0);
    chk($sformatf("v%0d resp rd_sel", n), 32'(rd_sel), 32'(v.exp_rdsel));
    chk($sformatf("v%0d resp ack", n), 32'(m_ack), 32'd0);
    @(negedge clk);
    chk($sformatf("v%0d ack", n), 32'(m_ack), 32'd1);
    chk($sformatf("v%0d err", n), 32'(m_err), 32'(v.exp_err));
    chk($sformatf("v%0d rdata", n), m_rdata, v.exp_rdata);
    chk($sformatf("v%0d ack rd_sel", n), 32'(rd_sel), 32'(RD_SEL_NONE));
  endtask

  initial begin
    vecs[0] = '{1'b0, 16'h0304, 32'h0,        7'b0001000, 1'b0, 4'd3, 1'b0, 32'hDEADBEEF};
    vecs[1] = '{1'b1, 16'h0610, 32'h12345678, 7'b1000000, 1'b1, 4'd6, 1'b0, 32'hDEADBEEF};
    vecs[2] = '{1'b0, 16'h0900, 32'h0,        7'b0000000, 1'b0, 4'd7, 1'b1, 32'h0};
    vecs[3] = '{1'b0, 16'h05AA, 32'h0,        7'b0100000, 1'b0, 4'd5, 1'b0, 32'h10000005};
    vecs[4] = '{1'b1, 16'hFF01, 32'hCAFEF00D, 7'b0000000, 1'b0, 4'd7, 1'b1, 32'h10000005};
    vecs[5] = '{1'b0, 16'h0000, 32'h0,        7'b0000001, 1'b0, 4'd0, 1'b0, 32'h10000000};
    vecs[6] = '{1'b1, 16'h0180, 32'h0BADF00D, 7'b0000010, 1'b1, 4'd1, 1'b0, 32'h10000000};
    vecs[7] = '{1'b0, 16'h06FF, 32'h0,        7'b1000000, 1'b0, 4'd6, 1'b0, 32'h10000006};
    vecs[8] = '{1'b0, 16'h0700, 32'h0,        7'b0000000, 1'b0, 4'd7, 1'b1, 32'h0};

    rst = 1'b1; m_req = 1'b0; m_wr = 1'b0; m_addr = '0; m_wdata = '0;
    repeat (2) @(negedge clk);
    chk("rst ready", 32'(m_ready), 32'd0);
    chk("rst ack", 32'(m_ack), 32'd0);
    chk("rst err", 32'(m_err), 32'd0);
    chk("rst rdata", m_rdata, 32'h0);
    chk("rst s_sel", 32'(s_sel), 32'd0);
    chk("rst s_wr", 32'(s_wr), 32'd0);
    chk("rst s_addr", 32'(s_addr), 32'd0);
    chk("rst s_wdata", s_wdata, 32'h0);
    chk("rst rd_sel", 32'(rd_sel), 32'(RD_SEL_NONE));
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("idle%0d ready", i), 32'(m_ready), 32'd1);
      chk($sformatf("idle%0d rd_sel", i), 32'(rd_sel), 32'(RD_SEL_NONE));
      chk($sformatf("idle%0d s_sel", i), 32'(s_sel), 32'd0);
      chk($sformatf("idle%0d ack", i), 32'(m_ack), 32'd0);
    end

    for (int i = 0; i < 9; i++) run_txn(i, vecs[i]);

    // Back-to-back reads to slave 0 then 6 with m_req held high throughout.
    m_req = 1'b1; m_wr = 1'b0; m_addr = 16'h0000;
    @(negedge clk);
    chk("b2b0 s_sel", 32'(s_sel), 32'b0000001);
    m_addr = 16'h0600;
    @(negedge clk);
    chk("b2b0 resp rd_sel", 32'(rd_sel), 32'd0);
    @(negedge clk);
    chk("b2b0 ack", 32'(m_ack), 32'd1);
    chk("b2b0 rdata", m_rdata, 32'h10000000);
    chk("b2b0 ready", 32'(m_ready), 32'd1);
    @(negedge clk);
    m_req = 1'b0;
    chk("b2b1 s_sel", 32'(s_sel), 32'b1000000);
    chk("b2b1 rd_sel", 32'(rd_sel), 32'd6);
    chk("b2b1 no ack", 32'(m_ack), 32'd0);
    @(negedge clk);
    @(negedge clk);
    chk("b2b1 ack", 32'(m_ack), 32'd1);
    chk("b2b1 rdata", m_rdata, 32'h10000006);
    @(negedge clk);
    chk("b2b end s_sel", 32'(s_sel), 32'd0);
    chk("b2b end ack", 32'(m_ack), 32'd0);

    // A short m_req pulse during ACCESS/RESP must not start a transaction.
    m_req = 1'b1; m_addr = 16'h0300;
    @(negedge clk);
    m_req = 1'b1; m_addr = 16'h0100;
    @(negedge clk);
    m_req = 1'b0;
    @(negedge clk);
    chk("pulse ack", 32'(m_ack), 32'd1);
    chk("pulse rdata", m_rdata, 32'hDEADBEEF);
    @(negedge clk);
    chk("pulse s_sel", 32'(s_sel), 32'd0);
    chk("pulse rd_sel", 32'(rd_sel), 32'(RD_SEL_NONE));
    chk("pulse ready", 32'(m_ready), 32'd1);

    // Reset asserted during RESP of a read to slave 2 aborts it.
    m_req = 1'b1; m_wr = 1'b0; m_addr = 16'h0244; m_wdata = 32'h00000055;
    @(negedge clk);
    m_req = 1'b0;
    chk("abort acc s_sel", 32'(s_sel), 32'b0000100);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("abort ack", 32'(m_ack), 32'd0);
    chk("abort rdata", m_rdata, 32'h0);
    chk("abort s_addr", 32'(s_addr), 32'd0);
    chk("abort s_wdata", s_wdata, 32'h0);
    chk("abort rd_sel", 32'(rd_sel), 32'(RD_SEL_NONE));
    chk("abort ready in rst", 32'(m_ready), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    chk("abort ready", 32'(m_ready), 32'd1);
    chk("abort no ack", 32'(m_ack), 32'd0);

    // Request coincident with reset is dropped.
    m_req = 1'b1; m_addr = 16'h0100; rst = 1'b1;
    @(negedge clk);
    chk("simul s_sel", 32'(s_sel), 32'd0);
    chk("simul ready", 32'(m_ready), 32'd0);
    rst = 1'b0; m_req = 1'b0;
    @(negedge clk);
    chk("simul s_sel2", 32'(s_sel), 32'd0);
    chk("simul ready2", 32'(m_ready), 32'd1);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
